// File: rtl/cmsdk_ahb_to_apb_async_p_if.sv
// APB bus bundle between the APB-domain bridge half and its APB slaves.
//   master : bridge side; drives PSEL/PENABLE/PADDR/PWRITE/PPROT/PSTRB/PWDATA,
//            receives PRDATA/PREADY/PSLVERR.
//   slave  : peripheral side, the mirror image.
interface cmsdk_ahb_to_apb_async_p_if #(
    parameter int ADDRWIDTH = 16
) ();
    logic                 PSEL;
    logic                 PENABLE;
    logic [ADDRWIDTH-1:0] PADDR;
    logic                 PWRITE;
    logic [2:0]           PPROT;
    logic [3:0]           PSTRB;
    logic [31:0]          PWDATA;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PPROT, PSTRB, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PPROT, PSTRB, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/cmsdk_ahb_to_apb_async_p.sv
// APB-domain half of the asynchronous AHB-to-APB bridge.
// A toggle on s_req_p (HCLK domain) is synchronised into PCLK; each request
// then runs one APB transfer (or none, for a dummy request) and is answered
// with a toggle on s_ack_p, with s_rdata/s_resp holding the result.
//
// Ports:
//   PCLK, PRESET        clock and synchronous active-high reset
//   s_req_p             request toggle, asynchronous to PCLK
//   s_addr/s_trans_valid/s_write/s_prot/s_strb/s_wdata
//                       transfer payload, held stable by the AHB side
//   s_rdata, s_resp     captured read data and error
//   s_ack_p             acknowledge toggle back to the HCLK domain
//   apb                 APB master bus (interface)
//   APBACTIVE           clock-gating hint
//
// state  | meaning
// IDLE   | no transfer; waiting for req/ack mismatch
// SETUP  | PSEL high, PENABLE low (one cycle)
// ACCESS | PSEL and PENABLE high, waiting for PREADY
module cmsdk_ahb_to_apb_async_p #(
    parameter int ADDRWIDTH = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  s_req_p,
    input  logic [ADDRWIDTH-3:0]  s_addr,
    input  logic                  s_trans_valid,
    input  logic                  s_write,
    input  logic [1:0]            s_prot,
    input  logic [3:0]            s_strb,
    input  logic [31:0]           s_wdata,
    output logic [31:0]           s_rdata,
    output logic                  s_resp,
    output logic                  s_ack_p,
    cmsdk_ahb_to_apb_async_p_if.master apb,
    output logic                  APBACTIVE
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 req_s1_q, req_s2_q;
    logic                 ack_q, ack_d;
    logic                 resp_q, resp_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic [ADDRWIDTH-1:0] paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [2:0]           pprot_q, pprot_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic                 pending;

    // Only the second synchroniser stage is trusted; the raw toggle never
    // reaches any logic.
    assign pending = req_s2_q ^ ack_q;

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pprot_d   = pprot_q;
        pstrb_d   = pstrb_q;
        pwdata_d  = pwdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    if (s_trans_valid) begin
                        paddr_d  = {s_addr, 2'b00};
                        pwrite_d = s_write;
                        pstrb_d  = s_strb;
                        pwdata_d = s_wdata;
                        // Non-secure bit is never driven.
                        pprot_d  = {s_prot[1], 1'b0, s_prot[0]};
                        psel_d   = 1'b1;
                        state_d  = ST_SETUP;
                    end else begin
                        // Dummy request: answer without touching the bus.
                        ack_d  = ~ack_q;
                        resp_d = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    resp_d    = apb.PSLVERR;
                    if (!pwrite_q) begin
                        rdata_d = apb.PRDATA;
                    end
                    ack_d   = ~ack_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            req_s1_q  <= 1'b0;
            req_s2_q  <= 1'b0;
            ack_q     <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pprot_q   <= '0;
            pstrb_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_s1_q  <= s_req_p;
            req_s2_q  <= req_s1_q;
            ack_q     <= ack_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pprot_q   <= pprot_d;
            pstrb_q   <= pstrb_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign s_ack_p     = ack_q;
    assign s_resp      = resp_q;
    assign s_rdata     = rdata_q;
    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PPROT   = pprot_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PWDATA  = pwdata_q;

    assign APBACTIVE = (state_q != ST_IDLE) | pending;

endmodule

// File: tb/tb_cmsdk_ahb_to_apb_async_p.sv
module tb_cmsdk_ahb_to_apb_async_p;
    localparam int AW = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          s_req_p;
    logic [AW-3:0] s_addr;
    logic          s_trans_valid;
    logic          s_write;
    logic [1:0]    s_prot;
    logic [3:0]    s_strb;
    logic [31:0]   s_wdata;
    logic [31:0]   s_rdata;
    logic          s_resp;
    logic          s_ack_p;
    logic          APBACTIVE;

    int errors = 0;
    int checks = 0;

    cmsdk_ahb_to_apb_async_p_if #(.ADDRWIDTH(AW)) apb ();

    cmsdk_ahb_to_apb_async_p #(.ADDRWIDTH(AW)) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .s_req_p       (s_req_p),
        .s_addr        (s_addr),
        .s_trans_valid (s_trans_valid),
        .s_write       (s_write),
        .s_prot        (s_prot),
        .s_strb        (s_strb),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_resp        (s_resp),
        .s_ack_p       (s_ack_p),
        .apb           (apb),
        .APBACTIVE     (APBACTIVE)
    );

    always #5 PCLK = ~PCLK;

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        tick();
        tick();
        checks++; if (apb.PSEL !== 1'b0) begin errors++; $display("FAIL reset_psel got=%b exp=0", apb.PSEL); end
        checks++; if (apb.PENABLE !== 1'b0) begin errors++; $display("FAIL reset_penable got=%b exp=0", apb.PENABLE); end
        checks++; if (s_ack_p !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", s_ack_p); end
        checks++; if ({s_resp, s_rdata} !== 33'h0) begin errors++; $display("FAIL reset_rdata_resp got=%h exp=0", {s_resp, s_rdata}); end
        checks++; if ({apb.PADDR, apb.PPROT, apb.PSTRB, apb.PWDATA, apb.PWRITE} !== '0) begin errors++; $display("FAIL reset_apb_regs got=%h exp=0", {apb.PADDR, apb.PPROT, apb.PSTRB, apb.PWDATA, apb.PWRITE}); end
        checks++; if (APBACTIVE !== 1'b0) begin errors++; $display("FAIL reset_apbactive got=%b exp=0", APBACTIVE); end
        PRESET = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        s_trans_valid = 1'b1; s_write = 1'b1; s_addr = 14'h0C01;
        s_strb = 4'hF; s_wdata = 32'hA5A5_1234; s_prot = 2'b00;
        apb.PREADY = 1'b1; apb.PRDATA = 32'h1111_2222; apb.PSLVERR = 1'b0;
        s_req_p = 1'b1;
        tick();
        tick();
        checks++; if (apb.PSEL !== 1'b0) begin errors++; $display("FAIL wr_psel_early got=%b exp=0", apb.PSEL); end
        checks++; if (APBACTIVE !== 1'b1) begin errors++; $display("FAIL wr_apbactive_pending got=%b exp=1", APBACTIVE); end
        tick();
        checks++; if ({apb.PSEL, apb.PENABLE} !== 2'b10) begin errors++; $display("FAIL wr_setup got=%b exp=10", {apb.PSEL, apb.PENABLE}); end
        checks++; if (apb.PADDR !== 16'h3004) begin errors++; $display("FAIL wr_paddr got=%h exp=3004", apb.PADDR); end
        checks++; if (apb.PWDATA !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_pwdata got=%h exp=a5a51234", apb.PWDATA); end
        checks++; if ({apb.PWRITE, apb.PSTRB} !== 5'h1F) begin errors++; $display("FAIL wr_pwrite_pstrb got=%h exp=1f", {apb.PWRITE, apb.PSTRB}); end
        checks++; if (s_ack_p !== 1'b0) begin errors++; $display("FAIL wr_ack_early got=%b exp=0", s_ack_p); end
        tick();
        checks++; if ({apb.PSEL, apb.PENABLE} !== 2'b11) begin errors++; $display("FAIL wr_access got=%b exp=11", {apb.PSEL, apb.PENABLE}); end
        tick();
        checks++; if (s_ack_p !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", s_ack_p); end
        checks++; if ({apb.PSEL, apb.PENABLE} !== 2'b00) begin errors++; $display("FAIL wr_idle got=%b exp=00", {apb.PSEL, apb.PENABLE}); end
        checks++; if (s_resp !== 1'b0) begin errors++; $display("FAIL wr_resp got=%b exp=0", s_resp); end
        checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata_kept got=%h exp=0", s_rdata); end
        tick();
        checks++; if (APBACTIVE !== 1'b0) begin errors++; $display("FAIL wr_apbactive_done got=%b exp=0", APBACTIVE); end
    endtask

    task automatic test_read_wait_err();
        s_trans_valid = 1'b1; s_write = 1'b0; s_addr = 14'h0010;
        s_strb = 4'h0; s_wdata = 32'h0; s_prot = 2'b11;
        apb.PREADY = 1'b0; apb.PRDATA = 32'hDEAD_BEEF; apb.PSLVERR = 1'b0;
        s_req_p = 1'b0;
        tick(); tick(); tick();
        checks++; if (apb.PPROT !== 3'b101) begin errors++; $display("FAIL rd_pprot got=%b exp=101", apb.PPROT); end
        checks++; if (apb.PADDR !== 16'h0040) begin errors++; $display("FAIL rd_paddr got=%h exp=0040", apb.PADDR); end
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PPROT, s_ack_p} !== {2'b11, 1'b0, 16'h0040, 3'b101, 1'b1}) begin
                errors++;
                $display("FAIL rd_wait%0d got=%h exp=%h", i,
                         {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PADDR, apb.PPROT, s_ack_p},
                         {2'b11, 1'b0, 16'h0040, 3'b101, 1'b1});
            end
        end
        apb.PREADY = 1'b1; apb.PSLVERR = 1'b1;
        tick();
        checks++; if (s_ack_p !== 1'b0) begin errors++; $display("FAIL rd_ack got=%b exp=0", s_ack_p); end
        checks++; if (s_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got=%h exp=deadbeef", s_rdata); end
        checks++; if (s_resp !== 1'b1) begin errors++; $display("FAIL rd_resp got=%b exp=1", s_resp); end
        checks++; if (apb.PSEL !== 1'b0) begin errors++; $display("FAIL rd_psel_done got=%b exp=0", apb.PSEL); end
        apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
        tick(); tick(); tick();
        checks++; if ({s_ack_p, apb.PSEL} !== 2'b00) begin errors++; $display("FAIL rd_ack_once got=%b exp=00", {s_ack_p, apb.PSEL}); end
    endtask

    task automatic test_dummy();
        s_trans_valid = 1'b0; s_write = 1'b1; s_addr = 14'h0123;
        apb.PRDATA = 32'h5555_AAAA;
        s_req_p = 1'b1;
        tick(); tick();
        checks++; if (s_ack_p !== 1'b0) begin errors++; $display("FAIL dummy_ack_early got=%b exp=0", s_ack_p); end
        tick();
        checks++; if (s_ack_p !== 1'b1) begin errors++; $display("FAIL dummy_ack got=%b exp=1", s_ack_p); end
        checks++; if (s_resp !== 1'b0) begin errors++; $display("FAIL dummy_resp got=%b exp=0", s_resp); end
        checks++; if (s_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dummy_rdata got=%h exp=deadbeef", s_rdata); end
        tick(); tick();
        checks++; if ({apb.PSEL, s_ack_p, APBACTIVE} !== 3'b010) begin errors++; $display("FAIL dummy_after got=%b exp=010", {apb.PSEL, s_ack_p, APBACTIVE}); end
    endtask

    task automatic test_back_to_back();
        s_trans_valid = 1'b1; s_write = 1'b1; s_addr = 14'h0005;
        s_strb = 4'h3; s_wdata = 32'h0000_BEEF; s_prot = 2'b11;
        apb.PREADY = 1'b1; apb.PSLVERR = 1'b0;
        s_req_p = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (s_ack_p !== 1'b0) begin errors++; $display("FAIL b2b_ack1 got=%b exp=0", s_ack_p); end
        tick();
        s_addr = 14'h0006; s_wdata = 32'h0000_CAFE; s_prot = 2'b00; s_strb = 4'hC;
        s_req_p = 1'b1;
        tick(); tick();
        checks++; if (apb.PSEL !== 1'b0) begin errors++; $display("FAIL b2b_psel_early got=%b exp=0", apb.PSEL); end
        tick();
        checks++; if (apb.PSEL !== 1'b1) begin errors++; $display("FAIL b2b_psel got=%b exp=1", apb.PSEL); end
        checks++; if ({apb.PADDR, apb.PPROT, apb.PSTRB} !== {16'h0018, 3'b000, 4'hC}) begin errors++; $display("FAIL b2b_ctrl got=%h exp=%h", {apb.PADDR, apb.PPROT, apb.PSTRB}, {16'h0018, 3'b000, 4'hC}); end
        tick(); tick();
        checks++; if (s_ack_p !== 1'b1) begin errors++; $display("FAIL b2b_ack2 got=%b exp=1", s_ack_p); end
        tick(); tick(); tick();
        checks++; if ({apb.PSEL, s_ack_p} !== 2'b01) begin errors++; $display("FAIL b2b_no_dup got=%b exp=01", {apb.PSEL, s_ack_p}); end
    endtask

    task automatic test_reset_mid();
        s_trans_valid = 1'b1; s_write = 1'b0; s_addr = 14'h0100;
        apb.PREADY = 1'b0;
        s_req_p = 1'b0;
        tick(); tick(); tick(); tick();
        checks++; if ({apb.PSEL, apb.PENABLE} !== 2'b11) begin errors++; $display("FAIL rst_mid_access got=%b exp=11", {apb.PSEL, apb.PENABLE}); end
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        checks++; if ({apb.PSEL, apb.PENABLE, s_ack_p} !== 3'b000) begin errors++; $display("FAIL rst_mid_edge got=%b exp=000", {apb.PSEL, apb.PENABLE, s_ack_p}); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if ({apb.PSEL, APBACTIVE} !== 2'b00) begin errors++; $display("FAIL rst_mid_quiet got=%b exp=00", {apb.PSEL, APBACTIVE}); end
        apb.PREADY = 1'b1; apb.PRDATA = 32'h0BAD_F00D;
        s_req_p = 1'b1;
        tick(); tick(); tick();
        checks++; if (apb.PSEL !== 1'b1) begin errors++; $display("FAIL rst_mid_new_req got=%b exp=1", apb.PSEL); end
        tick(); tick();
        checks++; if ({s_ack_p, s_rdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL rst_mid_done got=%h exp=%h", {s_ack_p, s_rdata}, {1'b1, 32'h0BAD_F00D}); end
    endtask

    initial begin
        PRESET = 1'b1; s_req_p = 1'b0; s_addr = '0; s_trans_valid = 1'b0;
        s_write = 1'b0; s_prot = 2'b00; s_strb = 4'h0; s_wdata = 32'h0;
        apb.PRDATA = 32'h0; apb.PREADY = 1'b0; apb.PSLVERR = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait_err();
        test_dummy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmsdk_ahb_to_apb_async_p.md
Name: cmsdk_ahb_to_apb_async_p

Overview:
- APB-domain half of the asynchronous AHB-to-APB bridge; sits directly downstream of the AHB-domain half.
- Synchronises the toggling request from the HCLK domain into PCLK and runs one APB3/APB4 transfer per request.
- Returns read data and error status, then toggles an acknowledge back to the AHB side.
- Transfer payload (address, control, write data) is held stable by the AHB side from request toggle until the acknowledge is seen.

Parameters:
- ADDRWIDTH, 16, APB address width in bits; word address received is ADDRWIDTH-2 bits.

Ports:
- PCLK  in  1  APB clock; the block's only clock.
- PRESET  in  1  reset, synchronous to PCLK, active-high.
- s_req_p  in  1  request toggle from the HCLK domain; asynchronous to PCLK.
- s_addr  in  ADDRWIDTH-2  word address.
- s_trans_valid  in  1  1 = real transfer; 0 = dummy request.
- s_write  in  1  1 = write.
- s_prot  in  2  [0] privileged, [1] instruction.
- s_strb  in  4  byte strobes; all zero for reads.
- s_wdata  in  32  write data.
- s_rdata  out  32  captured read data.
- s_resp  out  1  captured PSLVERR.
- s_ack_p  out  1  acknowledge toggle to the HCLK domain.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDRWIDTH  APB byte address.
- PWRITE  out  1  APB write.
- PPROT  out  3  APB protection.
- PSTRB  out  4  APB write strobes.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.
- APBACTIVE  out  1  clock-gating hint: transfer pending or in progress.

Behaviour:
- All state is updated on posedge PCLK. PRESET=1 clears everything.
- Reset values: PSEL, PENABLE, PWRITE, s_ack_p, s_resp all 0; PADDR, PPROT, PSTRB, PWDATA, s_rdata all zero; sync flops 0; state IDLE.
- Request synchroniser:
  - Two flops: req_s1 <= s_req_p; req_s2 <= req_s1.
  - Only req_s2 is used internally; s_req_p never feeds logic directly.
- pending = (req_s2 != s_ack_p).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE with pending and s_trans_valid=1:
  - Capture PADDR = {s_addr, 2'b00}, PWRITE = s_write, PSTRB = s_strb, PWDATA = s_wdata.
  - PPROT = {s_prot[1], 1'b0, s_prot[0]}.
  - Set PSEL=1; go to SETUP.
- IDLE with pending and s_trans_valid=0:
  - No APB transfer.
  - Toggle s_ack_p, set s_resp=0; s_rdata unchanged; stay in IDLE.
- SETUP: set PENABLE=1; go to ACCESS. This takes exactly one cycle.
- ACCESS with PREADY=0: hold all APB outputs stable; unlimited wait states allowed.
- ACCESS with PREADY=1:
  - PSEL=0, PENABLE=0; go to IDLE.
  - s_resp <= PSLVERR.
  - If PWRITE=0, s_rdata <= PRDATA; otherwise s_rdata is unchanged.
  - Toggle s_ack_p in the same edge.
- s_rdata and s_resp are valid and held from the s_ack_p toggle until the next completion.
- Back-to-back requests: after the ack toggle, pending=0 until the AHB side toggles s_req_p again. No minimum gap beyond synchroniser latency.
- Latency: s_req_p toggle → PSEL high after 3 PCLK edges → minimum 2 further edges to the ack toggle (zero wait states).
- APBACTIVE = (state != IDLE) | pending; combinational from registers only.
- Reset mid-transfer:
  - PSEL and PENABLE drop on the reset edge; s_ack_p goes to 0.
  - The AHB side detects the req/ack mismatch and re-aligns; this block must not issue an APB transfer for a request seen only before reset.
- Address and control in APB outputs change only on IDLE→SETUP; PWDATA and PSTRB stay stable through ACCESS.
- Unused PPROT[1] (non-secure bit) is always 0.

Test Plan:
- Write with zero wait states:
  - Stimulus: s_req_p 0→1, s_trans_valid=1, s_write=1, s_addr=0x0C01, s_strb=4'hF, s_wdata=0xA5A5_1234, PREADY=1.
  - Required: PSEL on 3rd edge, PADDR=0x3004, PWDATA=0xA5A5_1234, PENABLE next cycle, s_ack_p=1 the cycle after, s_resp=0.
- Read with 3 wait states and error:
  - Stimulus: PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF, PSLVERR=1 on the ready cycle.
  - Required: APB outputs stable across the wait, s_rdata=0xDEAD_BEEF, s_resp=1, s_ack_p toggles exactly once.
- Dummy request:
  - Stimulus: toggle s_req_p with s_trans_valid=0.
  - Required: PSEL stays 0, s_ack_p toggles 3 edges after the req toggle, s_resp=0.
- Back-to-back:
  - Stimulus: toggle s_req_p again 1 cycle after the ack.
  - Required: second transfer starts, PSEL high 3 edges after the new toggle, no lost or duplicated transfer.
- Reset mid-ACCESS:
  - Stimulus: assert PRESET for 1 cycle while PENABLE=1.
  - Required: PSEL=PENABLE=0, s_ack_p=0 on the reset edge; no transfer until a new req_s2 mismatch appears.
- Protection mapping:
  - Stimulus: s_prot=2'b11.
  - Required: PPROT=3'b101; s_prot=2'b00 gives PPROT=3'b000.
